// File: rtl/vc_pkg.sv
// Shared definitions for the QSPI arbitration logic.
//   - arb_state_e : arbiter FSM states (idle, busy for icache, busy for dcache, done)
//   - ROM_MODE_*  : chip-select mapping modes coming from the QSPI registers
//   - CS_IDX*     : chip-select indices driven towards the QSPI engine
package vc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  // rom_mode encodings
  localparam logic [1:0] ROM_MODE_SPLIT2 = 2'b00;  // tag MSB selects CS2, else CS0
  localparam logic [1:0] ROM_MODE_FLAT   = 2'b01;  // everything on CS0
  localparam logic [1:0] ROM_MODE_SPLIT1 = 2'b10;  // tag MSB selects CS1, else CS0
  localparam logic [1:0] ROM_MODE_RW     = 2'b11;  // reads on CS1, dcache writes on CS0

  // chip-select indices
  localparam logic [1:0] CS_IDX0 = 2'd0;
  localparam logic [1:0] CS_IDX1 = 2'd1;
  localparam logic [1:0] CS_IDX2 = 2'd2;

endpackage

// File: rtl/qspi_cs_map.sv
// Combinational chip-select mapping for a QSPI line transfer.
// Also usable by the QSPI register decode.
// Ports:
//   rom_mode  in  2  mapping mode
//   tag_msb   in  1  most significant bit of the line tag (paddr MSB)
//   is_icache in  1  transfer belongs to the icache
//   push      in  1  dcache write-back (only meaningful when !is_icache)
//   mem       out 2  chip-select index 0..2
module qspi_cs_map
  import vc_pkg::*;
(
  input  logic [1:0] rom_mode,
  input  logic       tag_msb,
  input  logic       is_icache,
  input  logic       push,
  output logic [1:0] mem
);

  // mode decode to chip-select index
  always_comb begin
    mem = CS_IDX0;
    case (rom_mode)
      ROM_MODE_SPLIT2: mem = tag_msb ? CS_IDX2 : CS_IDX0;
      ROM_MODE_FLAT:   mem = CS_IDX0;
      ROM_MODE_SPLIT1: mem = tag_msb ? CS_IDX1 : CS_IDX0;
      ROM_MODE_RW:     mem = (is_icache || !push) ? CS_IDX1 : CS_IDX0;
      default:         mem = CS_IDX0;
    endcase
  end

endmodule

// File: rtl/qspi_arb.sv
// Arbiter sharing the single QSPI line-transfer engine between icache line
// fills and dcache fills/write-backs. Tag, direction and chip select are
// latched at grant and held for the whole line.
// Optional feature: define QSPI_ARB_WDOG_EN to add a transfer watchdog that
// forces completion after 2**WDOG_BITS-1 busy cycles and sets sticky wdog_err.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   i_req, i_tag         icache line request and tag
//   d_req, d_push, d_tag dcache request, write-back flag, tag
//   rom_mode             chip-select mapping mode
//   q_done               1-cycle pulse, engine finished the line
//   q_req, q_i_d, q_write, q_mem, q_paddr   latched request to the engine
//   i_gnt, d_gnt         current owner of the engine
//   wdog_err             sticky watchdog timeout (0 without the watchdog)
module qspi_arb
  import vc_pkg::*;
#(
  parameter int PA          = 24,
  parameter int LINE_LENGTH = 4,
  parameter int WDOG_BITS   = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_req,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   i_tag,
  input  logic                                d_req,
  input  logic                                d_push,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   d_tag,
  input  logic [1:0]                          rom_mode,
  input  logic                                q_done,
  output logic                                q_req,
  output logic                                q_i_d,
  output logic                                q_write,
  output logic [1:0]                          q_mem,
  output logic [PA-$clog2(LINE_LENGTH)-1:0]   q_paddr,
  output logic                                i_gnt,
  output logic                                d_gnt,
  output logic                                wdog_err
);

  localparam int TW = PA - $clog2(LINE_LENGTH);

  arb_state_e        state_r, state_n;
  logic              q_req_r, q_req_n;
  logic              q_i_d_r, q_i_d_n;
  logic              q_write_r, q_write_n;
  logic [1:0]        q_mem_r, q_mem_n;
  logic [TW-1:0]     q_paddr_r, q_paddr_n;
  logic              i_gnt_r, i_gnt_n;
  logic              d_gnt_r, d_gnt_n;
  // Set when the last completed line was icache: a tie then goes to dcache.
  // Reset value 0 therefore favours icache on the first tie.
  logic              prefer_d_r, prefer_d_n;

  logic              win_d_s;
  logic [TW-1:0]     win_tag_s;
  logic [1:0]        win_mem_s;
  logic              wdog_hit_s;

  assign win_d_s   = d_req & (~i_req | prefer_d_r);
  assign win_tag_s = win_d_s ? d_tag : i_tag;

  qspi_cs_map u_cs_map (
    .rom_mode  (rom_mode),
    .tag_msb   (win_tag_s[TW-1]),
    .is_icache (~win_d_s),
    .push      (d_push),
    .mem       (win_mem_s)
  );

`ifdef QSPI_ARB_WDOG_EN
  // One below all-ones: on this value the counter steps to all-ones and the
  // transfer is forced to complete on the same edge.
  localparam logic [WDOG_BITS-1:0] WDOG_PRE_C = {{(WDOG_BITS-1){1'b1}}, 1'b0};

  logic [WDOG_BITS-1:0] wdog_cnt_r;
  logic                 wdog_err_r;
  logic                 busy_s;

  assign busy_s     = (state_r == ARB_BUSY_I) || (state_r == ARB_BUSY_D);
  assign wdog_hit_s = busy_s && (wdog_cnt_r == WDOG_PRE_C);
  assign wdog_err   = wdog_err_r;

  // watchdog counter (cleared while idle, i.e. at grant) and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_r <= {WDOG_BITS{1'b0}};
      wdog_err_r <= 1'b0;
    end else begin
      if (state_r == ARB_IDLE) begin
        wdog_cnt_r <= {WDOG_BITS{1'b0}};
      end else if (busy_s) begin
        wdog_cnt_r <= wdog_cnt_r + {{(WDOG_BITS-1){1'b0}}, 1'b1};
      end else begin
        wdog_cnt_r <= wdog_cnt_r;
      end
      wdog_err_r <= wdog_err_r | wdog_hit_s;
    end
  end
`else
  // No watchdog: transfers wait for q_done indefinitely.
  assign wdog_hit_s = 1'b0;
  assign wdog_err   = 1'b0 & (WDOG_BITS != 0);
`endif

  // next-state and next-output logic
  always_comb begin
    state_n    = state_r;
    q_req_n    = q_req_r;
    q_i_d_n    = q_i_d_r;
    q_write_n  = q_write_r;
    q_mem_n    = q_mem_r;
    q_paddr_n  = q_paddr_r;
    i_gnt_n    = i_gnt_r;
    d_gnt_n    = d_gnt_r;
    prefer_d_n = prefer_d_r;
    case (state_r)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          state_n   = win_d_s ? ARB_BUSY_D : ARB_BUSY_I;
          q_req_n   = 1'b1;
          i_gnt_n   = ~win_d_s;
          d_gnt_n   = win_d_s;
          q_i_d_n   = ~win_d_s;
          q_write_n = win_d_s & d_push;
          q_mem_n   = win_mem_s;
          q_paddr_n = win_tag_s;
        end else begin
          state_n = ARB_IDLE;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        // Requests are not looked at here: a started line always completes.
        if (q_done || wdog_hit_s) begin
          state_n    = ARB_DONE;
          q_req_n    = 1'b0;
          i_gnt_n    = 1'b0;
          d_gnt_n    = 1'b0;
          prefer_d_n = (state_r == ARB_BUSY_I);
        end else begin
          state_n = state_r;
        end
      end
      ARB_DONE: begin
        // One dead cycle so the cache sees its hit before re-requesting.
        state_n = ARB_IDLE;
      end
      default: begin
        state_n = ARB_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ARB_IDLE;
      q_req_r    <= 1'b0;
      q_i_d_r    <= 1'b0;
      q_write_r  <= 1'b0;
      q_mem_r    <= CS_IDX0;
      q_paddr_r  <= {TW{1'b0}};
      i_gnt_r    <= 1'b0;
      d_gnt_r    <= 1'b0;
      prefer_d_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      q_req_r    <= q_req_n;
      q_i_d_r    <= q_i_d_n;
      q_write_r  <= q_write_n;
      q_mem_r    <= q_mem_n;
      q_paddr_r  <= q_paddr_n;
      i_gnt_r    <= i_gnt_n;
      d_gnt_r    <= d_gnt_n;
      prefer_d_r <= prefer_d_n;
    end
  end

  assign q_req   = q_req_r;
  assign q_i_d   = q_i_d_r;
  assign q_write = q_write_r;
  assign q_mem   = q_mem_r;
  assign q_paddr = q_paddr_r;
  assign i_gnt   = i_gnt_r;
  assign d_gnt   = d_gnt_r;

endmodule
